// File: rtl/mem_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_master_pkg
// Brief    : Shared widths and FSM state encoding for the memory master.
// Revision : 1.0 - initial release
// ============================================================================
package mem_master_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_master
// Brief    : Single-beat write / burst read master on a shared tristate bus.
// Revision : 1.0 - initial release
// ============================================================================
module mem_master #(
    parameter int ADDR_W = mem_master_pkg::ADDR_W,
    parameter int DATA_W = mem_master_pkg::DATA_W,
    parameter int LEN_W  = mem_master_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    inout  wire  [DATA_W-1:0] mem_data
);

    import mem_master_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_mem_write_en;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_wdata;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W:0]    r_issued;
    logic [LEN_W:0]    r_captured;
    logic              r_prime;
    logic              r_rsp_valid;
    logic              r_rsp_write;
    logic              r_rsp_last;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_accept;
    logic              w_issue;
    logic              w_capture;
    logic              w_last;
    logic [LEN_W:0]    w_beats;

    assign w_beats = {1'b0, r_len} + {{LEN_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The memory has one cycle of registered read latency, so capture starts
    // one edge after the first address is issued (r_prime).
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = req_write ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                w_state_nxt = ST_IDLE;
            end
            ST_RD: begin
                w_issue   = (r_issued != w_beats);
                w_capture = r_prime;
                w_last    = r_prime && (r_captured == {1'b0, r_len});
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_write_en <= 1'b0;
            r_mem_address  <= '0;
            r_wdata        <= '0;
            r_len          <= '0;
            r_issued       <= '0;
            r_captured     <= '0;
            r_prime        <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_write    <= 1'b0;
            r_rsp_last     <= 1'b0;
            r_rsp_rdata    <= '0;
        end else begin
            r_mem_write_en <= w_accept && req_write;
            r_rsp_valid    <= w_capture || (r_state == ST_WR);
            r_rsp_write    <= (r_state == ST_WR);
            r_rsp_last     <= w_last || (r_state == ST_WR);
            if (w_accept) begin
                r_mem_address <= req_addr;
                r_prime       <= 1'b0;
                r_captured    <= '0;
                if (req_write) begin
                    r_wdata  <= req_wdata;
                    r_issued <= '0;
                end else begin
                    r_len    <= req_len;
                    r_issued <= {{LEN_W{1'b0}}, 1'b1};
                end
            end else if (r_state == ST_RD) begin
                r_prime <= 1'b1;
                if (w_issue) begin
                    r_mem_address <= r_mem_address + 1'b1;
                    r_issued      <= r_issued + 1'b1;
                end
                if (w_capture) begin
                    r_captured  <= r_captured + 1'b1;
                    r_rsp_rdata <= mem_data;
                end
            end
        end
    end

    // Bus drive and write enable decode from one register: no overlap with
    // the memory, which drives only while the enable is low.
    assign mem_data     = r_mem_write_en ? r_wdata : {DATA_W{1'bz}};
    assign mem_write_en = r_mem_write_en;
    assign mem_address  = r_mem_address;
    assign req_ready    = (r_state == ST_IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_write    = r_rsp_write;
    assign rsp_last     = r_rsp_last;
    assign rsp_rdata    = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_master
// Brief    : Self-checking bench for mem_master with a registered-read memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [4:0] req_addr  = '0;
    logic [2:0] req_len   = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_write;
    logic [7:0] rsp_rdata;
    logic       rsp_last;
    logic       mem_write_en;
    logic [4:0] mem_address;
    wire  [7:0] mem_data;

    typedef struct {
        bit         wr;
        bit         last;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem   [0:31];
    logic [7:0] model [0:31];
    logic [7:0] mem_rd_q = 8'h00;
    int         cyc      = 0;
    int         n_vec    = 0;
    int         n_err    = 0;
    int         n_x      = 0;
    bit         chk_en   = 1'b0;

    mem_master dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_write    (rsp_write),
        .rsp_rdata    (rsp_rdata),
        .rsp_last     (rsp_last),
        .mem_write_en (mem_write_en),
        .mem_address  (mem_address),
        .mem_data     (mem_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: registered read, drives the bus only while write enable is low.
    assign mem_data = mem_write_en ? 8'bz : mem_rd_q;
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_address] <= mem_data;
        mem_rd_q <= mem[mem_address];
    end

    always @(negedge clk) begin
        if (chk_en && $isunknown(mem_data)) n_x++;
    end

    // Scoreboard: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (chk_en && !rst && rsp_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid wr=%0b data=%h at cyc %0d, required none",
                         rsp_write, rsp_rdata, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_write !== e.wr || rsp_last !== e.last || cyc !== e.cyc ||
                    (!e.wr && rsp_rdata !== e.data)) begin
                    n_err++;
                    $display("FAIL rsp_beat: got wr=%0b last=%0b data=%h cyc=%0d, required wr=%0b last=%0b data=%h cyc=%0d",
                             rsp_write, rsp_last, rsp_rdata, cyc, e.wr, e.last, e.data, e.cyc);
                end
            end
        end
    end

    task automatic do_req(input bit wr, input logic [4:0] addr, input logic [2:0] len,
                          input logic [7:0] wd);
        int   guard = 0;
        int   c0;
        exp_t e;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL req_ready_timeout: got req_ready=%0b, required 1", req_ready);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = len;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        c0 = cyc;
        if (wr) begin
            model[addr] = wd;
            e.wr = 1'b1; e.last = 1'b1; e.data = 8'h00; e.cyc = c0 + 1;
            sb.push_back(e);
        end else begin
            for (int k = 0; k <= int'(len); k++) begin
                logic [4:0] a;
                a = addr + 5'(k);
                e.wr = 1'b0; e.last = (k == int'(len)); e.data = model[a]; e.cyc = c0 + 2 + k;
                sb.push_back(e);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({mem_write_en, rsp_valid, rsp_write, rsp_last} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got we/valid/write/last=%b, required 0000",
                     {mem_write_en, rsp_valid, rsp_write, rsp_last});
        end
        n_vec++;
        if (mem_address !== 5'd0 || rsp_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h rdata=%h, required 00 00", mem_address, rsp_rdata);
        end
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got req_ready=%0b, required 1", req_ready);
        end
    endtask

    task automatic test_write;
        int hi = 0;
        do_req(1'b1, 5'd3, 3'd0, 8'hA5);
        @(negedge clk);
        n_vec++;
        if (mem_write_en !== 1'b1 || mem_address !== 5'd3 || mem_data !== 8'hA5) begin
            n_err++;
            $display("FAIL write_drive: got we=%0b addr=%h data=%h, required 1 03 a5",
                     mem_write_en, mem_address, mem_data);
        end
        hi = 1;
        repeat (4) begin
            @(negedge clk);
            if (mem_write_en) hi++;
        end
        n_vec++;
        if (hi !== 1) begin
            n_err++;
            $display("FAIL write_pulse: got we high %0d cycles, required 1", hi);
        end
        n_vec++;
        if (mem[3] !== 8'hA5 || sb.size() !== 0) begin
            n_err++;
            $display("FAIL write_commit: got mem[3]=%h pending=%0d, required a5 0", mem[3], sb.size());
        end
    endtask

    task automatic test_read_burst(input logic [4:0] addr, input logic [2:0] len);
        int guard = 0;
        do_req(1'b0, addr, len, 8'h00);
        @(negedge clk);
        while (!(rsp_valid && rsp_last) && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (req_ready !== 1'b1 || rsp_last !== 1'b1) begin
            n_err++;
            $display("FAIL read_end_%0h: got last=%0b req_ready=%0b, required 1 1", addr, rsp_last, req_ready);
        end
        @(negedge clk);
        n_vec++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL read_drain_%0h: got %0d pending beats, required 0", addr, sb.size());
        end
    endtask

    task automatic test_back_to_back;
        do_req(1'b1, 5'd7, 3'd0, 8'h5A);
        test_read_burst(5'd7, 3'd0);
        n_vec++;
        if (rsp_rdata !== 8'h5A || mem[7] !== 8'h5A) begin
            n_err++;
            $display("FAIL raw_data: got rdata=%h mem[7]=%h, required 5a 5a", rsp_rdata, mem[7]);
        end
    endtask

    task automatic test_abort;
        int c0;
        int seen = 0;
        do_req(1'b0, 5'd0, 3'd7, 8'h00);
        c0 = cyc;
        while (cyc < c0 + 4) @(negedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0 || mem_write_en !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset: got valid=%0b we=%0b, required 0 0", rsp_valid, mem_write_en);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_ready: got req_ready=%0b, required 1", req_ready);
        end
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d rsp pulses, required 0", seen);
        end
    endtask

    task automatic test_contention;
        n_vec++;
        if (n_x !== 0) begin
            n_err++;
            $display("FAIL bus_contention: got %0d unknown bus cycles, required 0", n_x);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]   = 8'(i) + 8'h10;
            model[i] = 8'(i) + 8'h10;
        end
        test_reset();
        test_write();
        test_read_burst(5'd4, 3'd3);
        test_read_burst(5'd30, 3'd3);
        test_back_to_back();
        test_abort();
        test_contention();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameters: ADDR_W = 5, address width; DATA_W = 8, data width; LEN_W = 3, burst-length field width.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  high when the block can accept a request.
REQ-006 req_write  in  1  1 = single-beat write, 0 = read burst.
REQ-007 req_addr  in  5  start address.
REQ-008 req_len  in  3  read beats minus 1 (1..8 beats); ignored for writes.
REQ-009 req_wdata  in  8  write data.
REQ-010 rsp_valid  out  1  one-cycle pulse per read beat or write completion.
REQ-011 rsp_write  out  1  qualifies rsp_valid as write completion.
REQ-012 rsp_rdata  out  8  read beat data, valid with rsp_valid and rsp_write = 0.
REQ-013 rsp_last  out  1  final beat of a burst (always 1 for a write completion).
REQ-014 mem_write_en  out  1  drives the memory write enable.
REQ-015 mem_address  out  5  drives the memory address.
REQ-016 mem_data  inout  8  shared bidirectional data bus.

Function
REQ-017 FSM states: IDLE, WR, RD.
REQ-018 req_ready = (state == IDLE); handshake occurs at an edge where req_valid && req_ready.
REQ-019 IDLE: mem_write_en = 0 and mem_address holds its last value; mem_data is released (Z).
REQ-020 Write accept at edge E0 -> WR for exactly one cycle, with mem_write_en = 1, mem_address = req_addr and mem_data = req_wdata, all registered.
REQ-021 WR -> IDLE at E1; at E1 the memory commits the write.
REQ-022 In the cycle after E1: rsp_valid = 1, rsp_write = 1, rsp_last = 1.
REQ-023 mem_data is driven only while mem_write_en = 1, and is decoded from the same register so there is zero overlap with the memory's read drive.
REQ-024 Read accept at E0 -> RD, with mem_write_en = 0 and mem_address = req_addr.
REQ-025 In RD, mem_address increments by 1 each edge until req_len+1 addresses have been issued; it wraps mod 32 (31 -> 0).
REQ-026 At each edge from E2 onward, mem_data is captured into rsp_rdata; beat k (0-based) is captured at edge E(k+2) and holds mem[req_addr+k mod 32].
REQ-027 rsp_valid is high in the cycle after each capture edge; rsp_last is high on beat req_len.
REQ-028 First-beat latency is 3 cycles from accept; throughput is 1 beat/cycle with no gaps.
REQ-029 After the last capture, the state returns to IDLE at that same edge; req_ready is high in the following cycle.
REQ-030 Two counters, 4 bits each: issued and captured; they saturate at req_len+1.
REQ-031 There is no response backpressure; the consumer must accept every rsp_valid pulse.
REQ-032 req_valid while busy is ignored; the request is not queued; the requester holds it until req_ready.
REQ-033 A read issued right after a write observes the written value; no forwarding logic is needed because the write commits at E1.

Reset
REQ-034 While rst is high: state = IDLE, mem_write_en = 0, mem_address = 0, mem_data = Z, rsp_valid = 0, rsp_write = 0, rsp_last = 0, rsp_rdata = 0, counters = 0.
REQ-035 Reset mid-burst or mid-write aborts immediately; no further rsp_valid is produced for the aborted request.
REQ-036 A write whose enable is dropped by an asynchronous reset before its commit edge is lost.
REQ-037 req_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-038 Package mem_master_pkg holds the state enum and the ADDR_W, DATA_W and LEN_W constants.
REQ-039 No sub-module; the FSM, counters and tristate driver live in a single module.

Verification
REQ-040 The bench pairs mem_master with the existing memory model, preloaded with mem[i] = i+8'h10.
REQ-041 Write 8'hA5 to address 3 -> mem_write_en high for exactly 1 cycle; rsp_valid with rsp_write = 1 two cycles after accept; mem[3] = 8'hA5.
REQ-042 Read addr 4, len 3 -> 4 back-to-back rsp_valid pulses with data 8'h14, 8'h15, 8'h16, 8'h17; first pulse 3 cycles after accept; rsp_last on 8'h17.
REQ-043 Read addr 30, len 3 -> data 8'h2E, 8'h2F, 8'h10, 8'h11 (wrap to 0).
REQ-044 Write 8'h5A to address 7, then on the next req_ready a read of address 7 with len 0 -> rsp_rdata = 8'h5A.
REQ-045 rst asserted during beat 2 of an 8-beat read -> rsp_valid stays 0 from that point; mem_write_en = 0; req_ready = 1 after release.
REQ-046 Bus-contention checker: mem_data never receives driver conflicts (X) throughout all scenarios.
